// File: rtl/sz_fit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sz_fit_pkg                                                        |
// | Shared constants and arithmetic helpers for the SZ 1-D curve-fit  |
// | predictor: output code values, signed saturation, absolute value. |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package sz_fit_pkg;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_ORD0 = 2'b01;
  localparam logic [1:0] CODE_ORD1 = 2'b10;
  localparam logic [1:0] CODE_ORD2 = 2'b11;

  // Helpers operate on a fixed wide container; callers sign-extend in and
  // truncate out. Supports sample widths up to SZ_MAXW-3.
  localparam int SZ_MAXW = 64;

  // Clamp v to the signed range of a w-bit value.
  function automatic logic signed [SZ_MAXW-1:0] sat_s(
    input logic signed [SZ_MAXW-1:0] v,
    input int                        w
  );
    logic signed [SZ_MAXW-1:0] hi;
    logic signed [SZ_MAXW-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      sat_s = hi;
    else if (v < lo) sat_s = lo;
    else             sat_s = v;
  endfunction

  // Absolute value; callers guarantee v is never the most negative value.
  function automatic logic signed [SZ_MAXW-1:0] abs_s(
    input logic signed [SZ_MAXW-1:0] v
  );
    abs_s = (v < 64'sd0) ? -v : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sz_fit_hist.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sz_fit_hist                                                       |
// | Per-channel history register file {h1,h2,h3,cnt}. One read port  |
// | feeding prediction, one write port that shifts in a new           |
// | reconstructed value for the written channel.                      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module sz_fit_hist #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH_W-1:0]  rd_ch_i,
  output logic [WIDTH-1:0] rd_h1_o,
  output logic [WIDTH-1:0] rd_h2_o,
  output logic [WIDTH-1:0] rd_h3_o,
  output logic [1:0]       rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [CH_W-1:0]  wr_ch_i,
  input  logic [WIDTH-1:0] wr_recon_i,
  input  logic [1:0]       wr_cnt_i
);

  logic [WIDTH-1:0] h1_q  [CHANNELS];
  logic [WIDTH-1:0] h2_q  [CHANNELS];
  logic [WIDTH-1:0] h3_q  [CHANNELS];
  logic [1:0]       cnt_q [CHANNELS];

  // Shift the written channel's history by one and store its new count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        h1_q[i]  <= '0;
        h2_q[i]  <= '0;
        h3_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      h1_q[wr_ch_i]  <= wr_recon_i;
      h2_q[wr_ch_i]  <= h1_q[wr_ch_i];
      h3_q[wr_ch_i]  <= h2_q[wr_ch_i];
      cnt_q[wr_ch_i] <= wr_cnt_i;
    end
  end

  assign rd_h1_o  = h1_q[rd_ch_i];
  assign rd_h2_o  = h2_q[rd_ch_i];
  assign rd_h3_o  = h3_q[rd_ch_i];
  assign rd_cnt_o = cnt_q[rd_ch_i];

endmodule
`default_nettype wire

// File: rtl/sz_fit_1d_mc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sz_fit_1d_mc                                                      |
// | Multi-channel order-0/1/2 extrapolating predictor. Three-stage    |
// | pipeline: predict, error, select/bound. Same-channel hazards stall|
// | the input so each sample sees its predecessor's reconstruction.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module sz_fit_1d_mc
  import sz_fit_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_ch,
  input  logic             in_first,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] err_bound,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_ch,
  output logic [1:0]       out_code,
  output logic [WIDTH-1:0] out_recon,
  output logic [WIDTH:0]   out_err
);

  localparam int PW = WIDTH + 3;  // prediction headroom: 3*h1 + 3*h2 + h3
  localparam int EW = WIDTH + 2;  // error width

  // ---------------- handshake ----------------
  logic s1_valid_q, s2_valid_q, out_valid_q;
  logic [CH_W-1:0] s1_ch_q, s2_ch_q, out_ch_q;
  logic advance, hazard, accept;

  assign advance  = ~(out_valid_q & ~out_ready);
  assign hazard   = (s1_valid_q && (s1_ch_q == in_ch)) ||
                    (s2_valid_q && (s2_ch_q == in_ch));
  assign in_ready = rst & advance & ~hazard;
  assign accept   = in_valid & in_ready;

  // ---------------- stage 1: history read, predictions ----------------
  logic [WIDTH-1:0] h1_rd, h2_rd, h3_rd;
  logic [1:0]       cnt_rd;
  logic signed [PW-1:0] h1_x, h2_x, h3_x, p1_raw, p2_raw;
  logic [WIDTH-1:0] p1_sat, p2_sat;

  logic             wr_en;
  logic [1:0]       wr_cnt;
  logic [WIDTH-1:0] recon_d;

  sz_fit_hist #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W)) u_hist (
    .clk        (clk),
    .rst        (rst),
    .rd_ch_i    (in_ch),
    .rd_h1_o    (h1_rd),
    .rd_h2_o    (h2_rd),
    .rd_h3_o    (h3_rd),
    .rd_cnt_o   (cnt_rd),
    .wr_en_i    (wr_en),
    .wr_ch_i    (s2_ch_q),
    .wr_recon_i (recon_d),
    .wr_cnt_i   (wr_cnt)
  );

  assign h1_x   = {{3{h1_rd[WIDTH-1]}}, h1_rd};
  assign h2_x   = {{3{h2_rd[WIDTH-1]}}, h2_rd};
  assign h3_x   = {{3{h3_rd[WIDTH-1]}}, h3_rd};
  assign p1_raw = (h1_x <<< 1) - h2_x;
  assign p2_raw = (h1_x <<< 1) + h1_x - (h2_x <<< 1) - h2_x + h3_x;
  assign p1_sat = WIDTH'(sat_s(64'(p1_raw), WIDTH));
  assign p2_sat = WIDTH'(sat_s(64'(p2_raw), WIDTH));

  logic [WIDTH-1:0] s1_data_q, s1_bound_q, s1_p0_q, s1_p1_q, s1_p2_q;
  logic [1:0]       s1_cnt_q;

  // Capture the accepted sample with its predictions; a block start sees an empty history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_data_q  <= '0;
      s1_bound_q <= '0;
      s1_p0_q    <= '0;
      s1_p1_q    <= '0;
      s1_p2_q    <= '0;
      s1_cnt_q   <= '0;
    end else if (advance) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_ch_q    <= in_ch;
        s1_data_q  <= in_data;
        s1_bound_q <= err_bound;
        s1_p0_q    <= h1_rd;
        s1_p1_q    <= p1_sat;
        s1_p2_q    <= p2_sat;
        s1_cnt_q   <= in_first ? 2'd0 : cnt_rd;
      end
    end
  end

  // ---------------- stage 2: absolute errors, eligibility ----------------
  logic signed [EW-1:0] d_x, q0_x, q1_x, q2_x;
  logic [EW-1:0]        e0, e1, e2;

  assign d_x  = {{2{s1_data_q[WIDTH-1]}}, s1_data_q};
  assign q0_x = {{2{s1_p0_q[WIDTH-1]}}, s1_p0_q};
  assign q1_x = {{2{s1_p1_q[WIDTH-1]}}, s1_p1_q};
  assign q2_x = {{2{s1_p2_q[WIDTH-1]}}, s1_p2_q};
  assign e0   = EW'(abs_s(64'(d_x - q0_x)));
  assign e1   = EW'(abs_s(64'(d_x - q1_x)));
  assign e2   = EW'(abs_s(64'(d_x - q2_x)));

  logic [WIDTH-1:0] s2_data_q, s2_bound_q, s2_p0_q, s2_p1_q, s2_p2_q;
  logic [EW-1:0]    s2_e0_q, s2_e1_q, s2_e2_q;
  logic [2:0]       s2_elig_q;
  logic [1:0]       s2_cnt_q;

  // Register errors and which models have enough history to be used.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_ch_q    <= '0;
      s2_data_q  <= '0;
      s2_bound_q <= '0;
      s2_p0_q    <= '0;
      s2_p1_q    <= '0;
      s2_p2_q    <= '0;
      s2_e0_q    <= '0;
      s2_e1_q    <= '0;
      s2_e2_q    <= '0;
      s2_elig_q  <= '0;
      s2_cnt_q   <= '0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_ch_q    <= s1_ch_q;
        s2_data_q  <= s1_data_q;
        s2_bound_q <= s1_bound_q;
        s2_p0_q    <= s1_p0_q;
        s2_p1_q    <= s1_p1_q;
        s2_p2_q    <= s1_p2_q;
        s2_e0_q    <= e0;
        s2_e1_q    <= e1;
        s2_e2_q    <= e2;
        s2_elig_q  <= {s1_cnt_q > 2'd2, s1_cnt_q > 2'd1, s1_cnt_q > 2'd0};
        s2_cnt_q   <= s1_cnt_q;
      end
    end
  end

  // ---------------- stage 3: selection, bound check, writeback ----------------
  logic             found;
  logic [EW-1:0]    best_e;
  logic [1:0]       sel_code, code_d;
  logic [WIDTH-1:0] sel_p;
  logic [WIDTH:0]   err_d;

  // Lowest error wins; strict less-than keeps ties on the lower order.
  always_comb begin
    found    = 1'b0;
    best_e   = '0;
    sel_code = CODE_NONE;
    sel_p    = s2_data_q;
    code_d   = CODE_NONE;
    recon_d  = s2_data_q;
    err_d    = '0;
    if (s2_elig_q[0]) begin
      found = 1'b1; best_e = s2_e0_q; sel_code = CODE_ORD0; sel_p = s2_p0_q;
    end
    if (s2_elig_q[1] && (!found || (s2_e1_q < best_e))) begin
      found = 1'b1; best_e = s2_e1_q; sel_code = CODE_ORD1; sel_p = s2_p1_q;
    end
    if (s2_elig_q[2] && (!found || (s2_e2_q < best_e))) begin
      found = 1'b1; best_e = s2_e2_q; sel_code = CODE_ORD2; sel_p = s2_p2_q;
    end
    if (found && (best_e <= {2'b00, s2_bound_q})) begin
      code_d  = sel_code;
      recon_d = sel_p;
    end
    err_d = {s2_data_q[WIDTH-1], s2_data_q} - {recon_d[WIDTH-1], recon_d};
  end

  assign wr_en  = s2_valid_q & advance;
  assign wr_cnt = (s2_cnt_q == 2'd3) ? 2'd3 : s2_cnt_q + 2'd1;

  logic [1:0]       out_code_q;
  logic [WIDTH-1:0] out_recon_q;
  logic [WIDTH:0]   out_err_q;

  // Output register; held stable while downstream stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_code_q  <= CODE_NONE;
      out_recon_q <= '0;
      out_err_q   <= '0;
    end else if (advance) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_ch_q    <= s2_ch_q;
        out_code_q  <= code_d;
        out_recon_q <= recon_d;
        out_err_q   <= err_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_code  = out_code_q;
  assign out_recon = out_recon_q;
  assign out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sz_fit_1d_mc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sz_fit_1d_mc                                                   |
// | Directed self-checking bench for sz_fit_1d_mc (WIDTH=16, 2 ch).   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_sz_fit_1d_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [0:0]  in_ch;
  logic        in_first;
  logic [15:0] in_data;
  logic [15:0] err_bound;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_ch;
  logic [1:0]  out_code;
  logic [15:0] out_recon;
  logic [16:0] out_err;

  int n_assert = 0;
  int n_fail   = 0;

  sz_fit_1d_mc #(.WIDTH(16), .CHANNELS(2), .CH_W(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_first  (in_first),
    .in_data   (in_data),
    .err_bound (err_bound),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_code  (out_code),
    .out_recon (out_recon),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ch, input logic first, input logic [15:0] d);
    in_valid = 1'b1;
    in_ch    = ch;
    in_first = first;
    in_data  = d;
  endtask

  // Present a sample, wait (bounded) for acceptance, leave at posedge+1.
  task automatic send(input string tag, input logic ch, input logic first, input logic [15:0] d);
    int k;
    k = 0;
    drive(ch, first, d);
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_acc"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result, check it and its latency, consume it.
  task automatic wait_out(input string tag, input int lat, input logic ch,
                          input logic [1:0] code, input logic [15:0] recon,
                          input logic [16:0] err);
    int k;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"},   k,   lat);
    chk({tag, "_ch"},    {31'd0, out_ch}, {31'd0, ch});
    chk({tag, "_code"},  {30'd0, out_code}, {30'd0, code});
    chk({tag, "_recon"}, {16'd0, out_recon}, {16'd0, recon});
    chk({tag, "_err"},   {15'd0, out_err}, {15'd0, err});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_first  = 1'b0;
    in_data   = '0;
    err_bound = 16'd2;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_code",  {30'd0, out_code},  32'd0);
    chk("rst_out_recon", {16'd0, out_recon}, 32'd0);
    chk("rst_out_err",   {15'd0, out_err},   32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Linear ramp on ch0
    send("c0a", 1'b0, 1'b1, 16'd10); wait_out("c0a", 2, 1'b0, 2'b00, 16'd10, 17'd0);
    send("c0b", 1'b0, 1'b0, 16'd20); wait_out("c0b", 2, 1'b0, 2'b00, 16'd20, 17'd0);
    send("c0c", 1'b0, 1'b0, 16'd30); wait_out("c0c", 2, 1'b0, 2'b10, 16'd30, 17'd0);
    send("c0d", 1'b0, 1'b0, 16'd40); wait_out("c0d", 2, 1'b0, 2'b10, 16'd40, 17'd0);

    // Flat-ish ch1
    send("c1a", 1'b1, 1'b1, 16'd7); wait_out("c1a", 2, 1'b1, 2'b00, 16'd7, 17'd0);
    send("c1b", 1'b1, 1'b0, 16'd7); wait_out("c1b", 2, 1'b1, 2'b01, 16'd7, 17'd0);
    send("c1c", 1'b1, 1'b0, 16'd8); wait_out("c1c", 2, 1'b1, 2'b01, 16'd7, 17'd1);

    // Back-to-back same channel: two stall cycles
    drive(1'b0, 1'b0, 16'd50);
    @(negedge clk); chk("b2b_rdy0", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'd60);
    @(negedge clk); chk("b2b_stall1", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_stall2", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_rdy3",   {31'd0, in_ready},  32'd1);
    chk("b2b_1_val",  {31'd0, out_valid}, 32'd1);
    chk("b2b_1_code", {30'd0, out_code},  32'd2);
    chk("b2b_1_recon",{16'd0, out_recon}, 32'd50);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out("b2b_2", 2, 1'b0, 2'b10, 16'd60, 17'd0);

    // Alternating channels
    drive(1'b0, 1'b0, 16'd70);
    @(negedge clk); chk("alt_rdy0", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'd7);
    @(negedge clk); chk("alt_rdy1", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'd80);
    @(negedge clk); chk("alt_stall", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("alt_rdy2",    {31'd0, in_ready},  32'd1);
    chk("alt_1_ch",    {31'd0, out_ch},    32'd0);
    chk("alt_1_code",  {30'd0, out_code},  32'd2);
    chk("alt_1_recon", {16'd0, out_recon}, 32'd70);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("alt_2_val",   {31'd0, out_valid}, 32'd1);
    chk("alt_2_ch",    {31'd0, out_ch},    32'd1);
    chk("alt_2_code",  {30'd0, out_code},  32'd1);
    chk("alt_2_recon", {16'd0, out_recon}, 32'd7);
    @(posedge clk); #1;
    wait_out("alt_3", 1, 1'b0, 2'b10, 16'd80, 17'd0);

    // Error bound is inclusive
    send("bnd_eq", 1'b1, 1'b0, 16'd9);  wait_out("bnd_eq", 2, 1'b1, 2'b01, 16'd7, 17'd2);
    send("bnd_gt", 1'b1, 1'b0, 16'd10); wait_out("bnd_gt", 2, 1'b1, 2'b00, 16'd10, 17'd0);

    // Saturation of order-1 prediction
    send("sat_a", 1'b0, 1'b1, 16'd30000); wait_out("sat_a", 2, 1'b0, 2'b00, 16'd30000, 17'd0);
    send("sat_b", 1'b0, 1'b0, 16'd32000); wait_out("sat_b", 2, 1'b0, 2'b00, 16'd32000, 17'd0);
    send("sat_c", 1'b0, 1'b0, 16'd32767); wait_out("sat_c", 2, 1'b0, 2'b10, 16'd32767, 17'd0);

    // Backpressure
    out_ready = 1'b0;
    drive(1'b0, 1'b1, 16'd100);
    @(negedge clk); chk("bp_rdyA", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'd13);
    @(negedge clk); chk("bp_rdyB", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'd100);
    @(negedge clk); chk("bp_haz", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_val",   {31'd0, out_valid}, 32'd1);
      chk("bp_hold_ch",    {31'd0, out_ch},    32'd0);
      chk("bp_hold_code",  {30'd0, out_code},  32'd0);
      chk("bp_hold_recon", {16'd0, out_recon}, 32'd100);
      chk("bp_hold_rdy",   {31'd0, in_ready},  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_rdy",   {31'd0, in_ready},  32'd1);
    chk("bp_rel_recon", {16'd0, out_recon}, 32'd100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_B_val",   {31'd0, out_valid}, 32'd1);
    chk("bp_B_ch",    {31'd0, out_ch},    32'd1);
    chk("bp_B_code",  {30'd0, out_code},  32'd2);
    chk("bp_B_recon", {16'd0, out_recon}, 32'd13);
    @(posedge clk); #1;
    wait_out("bp_C", 1, 1'b0, 2'b01, 16'd100, 17'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send("rst_pre", 1'b1, 1'b0, 16'd20);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rst_pre_recon", {16'd0, out_recon}, 32'd20);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("arst_out_recon", {16'd0, out_recon}, 32'd0);
    chk("arst_out_ch",    {31'd0, out_ch},    32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send("post_a", 1'b0, 1'b0, 16'd50); wait_out("post_a", 2, 1'b0, 2'b00, 16'd50, 17'd0);
    send("post_b", 1'b0, 1'b0, 16'd51); wait_out("post_b", 2, 1'b0, 2'b01, 16'd50, 17'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
